// File: rtl/path_tracer.sv
// rtl/path_tracer.sv - walks Dijkstra predecessor links from destination back to source
// and streams each node, destination first, reporting path length or an error pulse.
module path_tracer #(
  parameter int unsigned MAX_NODES   = 16,
  parameter int unsigned INDEX_WIDTH = 4,
  parameter logic [INDEX_WIDTH-1:0] UNVISITED = {INDEX_WIDTH{1'b1}}
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic [INDEX_WIDTH-1:0]           number_of_nodes_i,
  input  logic [INDEX_WIDTH-1:0]           source_i,
  input  logic [INDEX_WIDTH-1:0]           destination_i,
  input  logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened_i,
  output logic                             busy_o,
  output logic                             path_valid_o,
  input  logic                             path_ready_i,
  output logic [INDEX_WIDTH-1:0]           path_node_o,
  output logic                             path_last_o,
  output logic [INDEX_WIDTH-1:0]           path_length_o,
  output logic                             done_o,
  output logic                             error_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    EMIT  = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t                 state_q;
  logic [INDEX_WIDTH-1:0] current_q;
  logic [INDEX_WIDTH-1:0] src_q;
  logic [INDEX_WIDTH-1:0] n_q;
  logic [INDEX_WIDTH:0]   hop_q;
  logic [INDEX_WIDTH-1:0] length_q;
  logic                   busy_q;
  logic                   valid_q;
  logic [INDEX_WIDTH-1:0] node_q;
  logic                   last_q;
  logic                   done_q;
  logic                   error_q;
  logic [INDEX_WIDTH-1:0] prev_cur;
  logic                   check_fail;

  // Mux-style lookup so an index beyond MAX_NODES simply reads zero instead of going out of range.
  always_comb begin
    prev_cur = '0;
    for (int j = 0; j < MAX_NODES; j++) begin
      if (current_q == INDEX_WIDTH'(j)) begin
        prev_cur = prev_vector_flattened_i[j*INDEX_WIDTH +: INDEX_WIDTH];
      end
    end
  end

  assign check_fail = (n_q == '0) || (current_q >= n_q) ||
                      (hop_q == {1'b0, n_q}) ||
                      ((current_q != src_q) && (prev_cur == UNVISITED));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      current_q <= '0;
      src_q     <= '0;
      n_q       <= '0;
      hop_q     <= '0;
      length_q  <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      node_q    <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            src_q     <= source_i;
            current_q <= destination_i;
            n_q       <= number_of_nodes_i;
            hop_q     <= '0;
            length_q  <= '0;
            busy_q    <= 1'b1;
            state_q   <= CHECK;
          end
        end
        CHECK: begin
          if (check_fail) begin
            error_q <= 1'b1;
            state_q <= ERROR;
          end else begin
            valid_q <= 1'b1;
            node_q  <= current_q;
            last_q  <= (current_q == src_q);
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (path_ready_i) begin
            hop_q    <= hop_q + (INDEX_WIDTH+1)'(1);
            length_q <= length_q + INDEX_WIDTH'(1);
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            if (last_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              current_q <= prev_cur;
              state_q   <= CHECK;
            end
          end
        end
        DONE, ERROR: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign path_valid_o  = valid_q;
  assign path_node_o   = node_q;
  assign path_last_o   = last_q;
  assign path_length_o = length_q;
  assign done_o        = done_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_path_tracer.sv
// tb/tb_path_tracer.sv - table-driven scoreboard bench for path_tracer
module tb_path_tracer;

  localparam int MN = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] nn = '0, src = '0, dst = '0;
  logic [IW*MN-1:0] prev = '1;
  logic          busy, pvalid, pready, plast, done, error;
  logic [IW-1:0] pnode, plen;

  path_tracer #(.MAX_NODES(MN), .INDEX_WIDTH(IW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .number_of_nodes_i(nn), .source_i(src), .destination_i(dst),
    .prev_vector_flattened_i(prev),
    .busy_o(busy), .path_valid_o(pvalid), .path_ready_i(pready),
    .path_node_o(pnode), .path_last_o(plast), .path_length_o(plen),
    .done_o(done), .error_o(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [IW-1:0]    n, s, d;
    logic [IW*MN-1:0] p;
    logic             bp;
    logic             poke;
    logic [2:0]       nbeats;
    logic [15:0]      beats;
    logic             exp_err;
    logic [IW-1:0]    exp_len;
  } vec_t;

  vec_t vecs[7];
  logic [4:0] sb[$];

  function automatic logic [IW*MN-1:0] setp(input logic [IW*MN-1:0] p, input int idx, input logic [IW-1:0] v);
    logic [IW*MN-1:0] r;
    r = p;
    r[idx*IW +: IW] = v;
    return r;
  endfunction

  task automatic run_vec(input int vi, input vec_t v);
    int  cyc;
    bit  fin;
    bit  first_seen;
    bit  hold;
    logic [4:0] held;
    logic [4:0] exp_beat;
    logic       rnext;
    nn = v.n; src = v.s; dst = v.d; prev = v.p;
    for (int k = 0; k < int'(v.nbeats); k++)
      sb.push_back({(k == int'(v.nbeats) - 1) && !v.exp_err, v.beats[k*4 +: 4]});
    @(negedge clk);
    start = 1'b1;
    cyc = 0; fin = 0; first_seen = 0; hold = 0; held = '0;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (v.poke && cyc == 5) begin
        start = 1'b1;
        dst = 4'd3; src = 4'd3; nn = 4'd5;
      end
      if (!first_seen && (pvalid || error || done)) begin
        first_seen = 1;
        chk($sformatf("v%0d_latency", vi), cyc, 2);
      end
      if (done || error) begin
        fin = 1;
        chk($sformatf("v%0d_not_both", vi), {31'd0, done & error}, 0);
        chk($sformatf("v%0d_error", vi), {31'd0, error}, {31'd0, v.exp_err});
        chk($sformatf("v%0d_length", vi), plen, v.exp_len);
        chk($sformatf("v%0d_sb_empty", vi), sb.size(), 0);
        chk($sformatf("v%0d_valid_low", vi), {31'd0, pvalid}, 0);
      end else begin
        if (hold) begin
          chk($sformatf("v%0d_stable", vi), {pvalid, plast, pnode}, {1'b1, held});
        end
        rnext = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
        pready = rnext;
        hold = 0;
        if (pvalid && rnext) begin
          if (sb.size() == 0) begin
            chk($sformatf("v%0d_extra_beat", vi), {plast, pnode}, '1);
          end else begin
            exp_beat = sb.pop_front();
            chk($sformatf("v%0d_beat", vi), {plast, pnode}, exp_beat);
          end
        end else if (pvalid) begin
          hold = 1;
          held = {plast, pnode};
        end
      end
    end
    if (!fin) chk($sformatf("v%0d_timeout", vi), cyc, 0);
    @(negedge clk);
    start = 1'b0;
    pready = 1'b1;
    chk($sformatf("v%0d_pulse_end", vi), {30'd0, done, error}, 0);
    chk($sformatf("v%0d_idle", vi), {31'd0, busy}, 0);
    chk($sformatf("v%0d_len_hold", vi), plen, v.exp_len);
    sb.delete();
  endtask

  initial begin
    logic [IW*MN-1:0] chain, cyc_p, bad;
    int guard;
    pready = 1'b1;
    chain = '1;
    chain = setp(chain, 7, 4);
    chain = setp(chain, 4, 2);
    chain = setp(chain, 2, 0);
    cyc_p = '1;
    cyc_p = setp(cyc_p, 1, 2);
    cyc_p = setp(cyc_p, 2, 1);
    bad = '1;
    //          n   s   d   prev   bp poke nb  beats      err len
    vecs[0] = '{4'd10, 4'd0, 4'd7,  chain, 1'b0, 1'b0, 3'd4, 16'h0247, 1'b0, 4'd4};
    vecs[1] = '{4'd10, 4'd0, 4'd7,  chain, 1'b1, 1'b1, 3'd4, 16'h0247, 1'b0, 4'd4};
    vecs[2] = '{4'd10, 4'd0, 4'd5,  chain, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 4'd0};
    vecs[3] = '{4'd10, 4'd3, 4'd3,  bad,   1'b0, 1'b0, 3'd1, 16'h0003, 1'b0, 4'd1};
    vecs[4] = '{4'd10, 4'd0, 4'd12, chain, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 4'd0};
    vecs[5] = '{4'd4,  4'd0, 4'd1,  cyc_p, 1'b1, 1'b0, 3'd4, 16'h2121, 1'b1, 4'd4};
    vecs[6] = '{4'd0,  4'd0, 4'd0,  chain, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 4'd0};

    #1;
    chk("reset_outputs", {busy, pvalid, plast, done, error, pnode, plen}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset during the second EMIT of the chain trace must abort with no pulse.
    nn = 4'd10; src = 4'd0; dst = 4'd7; prev = chain; pready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(pvalid && pnode == 4'd4) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_reach_second_emit", {31'd0, pvalid}, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {busy, pvalid, plast, done, error, pnode, plen}, 0);
    guard = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || error) guard++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done || error || busy) guard++;
    end
    chk("rst_no_pulse", guard, 0);
    run_vec(7, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
